memory_write_data_encoder: RTL and testbench
============================================

# memory_write_data_encoder

Store-side counterpart of the load data decoder: accepts a store request (byte address, register data, access size) from the CPU's memory stage and writes it to a 32-bit word-only data memory that has no byte enables. Word stores are written directly; halfword and byte stores use a read-modify-write sequence so the untouched lanes of the word are preserved. Lane mapping is big-endian, the same convention the load decoder uses.

## Interface
- AW, 32, byte-address width; memory word address is AW-2 bits
- RD_TIMEOUT, 15, max cycles to wait for read data before flagging an error
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_addr  in  AW  byte address; ofs = req_addr[1:0]
- req_data  in  32  store data, right-justified (byte in [7:0], halfword in [15:0])
- req_ds  in  2  size: 0 word, 1 halfword, 2 byte, 3 illegal
- mem_addr  out  AW-2  word address (req_addr[AW-1:2], registered)
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  32  read data
- mem_rvalid  in  1  mem_rdata valid this cycle
- mem_wr  out  1  one-cycle write strobe
- mem_wdata  out  32  full word to write
- done  out  1  one-cycle pulse, coincident with mem_wr
- err  out  1  one-cycle pulse: illegal size or read timeout; no write issued

## Operation
- States: IDLE, READ, WAIT, WRITE, ERR.
- IDLE: req_ready=1. On req_valid: latch addr, data, ds, ofs. ds=0 -> WRITE with mem_wdata=req_data; ds=1/2 -> READ; ds=3 -> ERR.
- READ: mem_rd=1 for exactly one cycle -> WAIT; clear timeout counter.
- WAIT: on mem_rvalid, latch merged word -> WRITE. Otherwise count; counter reaching RD_TIMEOUT -> ERR.
- WRITE: mem_wr=1, done=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle -> IDLE; no mem_wr.
- Merge (big-endian): halfword ofs 0/1 -> data[15:0] into word[31:16]; ofs 2/3 -> into word[15:0]. Byte ofs 0..3 -> data[7:0] into word[31:24], [23:16], [15:8], [7:0] respectively. All other bits come from mem_rdata. Upper unused bits of req_data are ignored.
- Halfword ofs 1 and 3 are not misaligned errors; they map to the containing half, matching the load decoder.
- mem_rvalid outside WAIT is ignored. mem_rvalid in the same cycle as mem_rd (READ) is ignored.
- Reset: state IDLE; mem_rd, mem_wr, done, err = 0; mem_addr, mem_wdata = 0; req_ready = 1 after reset releases. Reset mid-operation abandons the request with no write.

## Timing
- Accept on the rising edge where req_valid & req_ready.
- Word store: mem_wr/done in cycle A+1 (A = accept cycle). Next accept possible at A+2.
- Sub-word store: mem_rd at A+1; if mem_rvalid at cycle R (R ≥ A+2), mem_wr/done at R+1; earliest write is A+3.
- Illegal ds: err at A+1.
- Timeout: err exactly RD_TIMEOUT+1 cycles after mem_rd if no mem_rvalid.
- All outputs registered; mem_addr and mem_wdata stable while mem_rd/mem_wr are high.
- Only one outstanding request; no pipelining.

## Structure
- Shared package: size encodings (DS_WORD=0, DS_HALF=1, DS_BYTE=2), state enum, lane-select constants.
- Sub-module write_data_merger: combinational (old word, data, ds, ofs) -> merged word; reused by verification as the reference model.
- Top: FSM, request latches, timeout counter.

## Test plan
- Word store addr 0x100, data 0xDEADBEEF, ds=0 -> mem_wr at A+1, mem_addr 0x40, mem_wdata 0xDEADBEEF, no mem_rd, done pulse.
- Byte store addr 0x101, data 0x000000AB, memory word 0x11223344, rvalid 2 cycles after mem_rd -> mem_wdata 0x11AB3344, mem_wr one cycle after rvalid.
- Halfword store ofs 3, data 0x0000CAFE, memory 0x11223344 -> mem_wdata 0x1122CAFE; ofs 0 same data -> 0xCAFE3344.
- ds=3 -> err pulse at A+1, no mem_rd/mem_wr, req_ready back high at A+2.
- Byte store with no mem_rvalid -> err exactly RD_TIMEOUT+1 cycles after mem_rd, no write; stray mem_rvalid while IDLE has no effect.
- rst_n low during WAIT -> IDLE next edge, no mem_wr, outputs zero; a new word store then completes normally.

Source files
------------

// File: rtl/memory_write_data_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_write_data_encoder_pkg
// Brief    : Shared size encodings, FSM state type and big-endian lane
//            selectors for the store-side write data encoder.
// Revision : 1.0 - initial release
// ============================================================================
package memory_write_data_encoder_pkg;

  // Access size encodings carried on req_ds
  localparam logic [1:0] DS_WORD = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_BYTE = 2'd2;
  localparam logic [1:0] DS_ILL  = 2'd3;

  // Byte offset within the word; lane 0 is the most significant byte
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/memory_write_data_encoder_merger.sv
`default_nettype none
// ============================================================================
// Module   : write_data_merger
// Brief    : Combinational big-endian merge of right-justified store data
//            into the old memory word. Unselected lanes keep old contents.
// Revision : 1.0 - initial release
// ============================================================================
module write_data_merger
  import memory_write_data_encoder_pkg::*;
(
  input  logic [31:0] i_oldWord,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_ds,
  input  logic [1:0]  i_ofs,
  output logic [31:0] o_merged
);

  // Overlay the selected lane(s) on the old word; a halfword at an odd
  // offset lands in its containing half, as the load decoder reads it
  always_comb begin
    o_merged = i_oldWord;
    case (i_ds)
      DS_WORD: o_merged = i_data;
      DS_HALF: begin
        if (i_ofs[1] == 1'b0) o_merged[31:16] = i_data[15:0];
        else                  o_merged[15:0]  = i_data[15:0];
      end
      DS_BYTE: begin
        case (i_ofs)
          LANE_0:  o_merged[31:24] = i_data[7:0];
          LANE_1:  o_merged[23:16] = i_data[7:0];
          LANE_2:  o_merged[15:8]  = i_data[7:0];
          default: o_merged[7:0]   = i_data[7:0];
        endcase
      end
      default: o_merged = i_oldWord;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_write_data_encoder.sv
`default_nettype none
// ============================================================================
// Module   : memory_write_data_encoder
// Brief    : Accepts a store request and writes it to a word-only memory.
//            Word stores write directly; sub-word stores read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module memory_write_data_encoder
  import memory_write_data_encoder_pkg::*;
#(
  parameter int AW         = 32,
  parameter int RD_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  input  logic [1:0]    req_ds,
  output logic [AW-3:0] mem_addr,
  output logic          mem_rd,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rvalid,
  output logic          mem_wr,
  output logic [31:0]   mem_wdata,
  output logic          done,
  output logic          err
);

  localparam int              CNT_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT - 1);

  state_t           r_state;
  logic [31:0]      r_data;
  logic [1:0]       r_ds;
  logic [1:0]       r_ofs;
  logic [CNT_W-1:0] r_timeoutCnt;
  logic [31:0]      w_merged;

  write_data_merger u_merger (
    .i_oldWord (mem_rdata),
    .i_data    (r_data),
    .i_ds      (r_ds),
    .i_ofs     (r_ofs),
    .o_merged  (w_merged)
  );

  // Store FSM: all strobes and memory-side outputs are registered here.
  // The timeout counter reaches CNT_MAX on the RD_TIMEOUT-th WAIT cycle,
  // so err appears RD_TIMEOUT+1 cycles after the read strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      req_ready    <= 1'b1;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      r_data       <= '0;
      r_ds         <= DS_WORD;
      r_ofs        <= '0;
      r_timeoutCnt <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_addr  <= req_addr[AW-1:2];
            r_data    <= req_data;
            r_ds      <= req_ds;
            r_ofs     <= req_addr[1:0];
            req_ready <= 1'b0;
            case (req_ds)
              DS_WORD: begin
                mem_wdata <= req_data;
                mem_wr    <= 1'b1;
                done      <= 1'b1;
                r_state   <= ST_WRITE;
              end
              DS_HALF, DS_BYTE: begin
                mem_rd  <= 1'b1;
                r_state <= ST_READ;
              end
              default: begin
                err     <= 1'b1;
                r_state <= ST_ERR;
              end
            endcase
          end
        end
        ST_READ: begin
          // Read data arriving alongside the strobe is not trusted
          r_timeoutCnt <= '0;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            mem_wdata <= w_merged;
            mem_wr    <= 1'b1;
            done      <= 1'b1;
            r_state   <= ST_WRITE;
          end else if (r_timeoutCnt == CNT_MAX) begin
            err     <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_timeoutCnt <= r_timeoutCnt + 1'b1;
          end
        end
        ST_WRITE, ST_ERR: begin
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_write_data_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_write_data_encoder
// Brief    : Directed self-checking bench for memory_write_data_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_write_data_encoder;

  localparam int AW         = 32;
  localparam int RD_TIMEOUT = 15;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [1:0]    req_ds;
  logic [AW-3:0] mem_addr;
  logic          mem_rd;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid;
  logic          mem_wr;
  logic [31:0]   mem_wdata;
  logic          done;
  logic          err;

  int nChecks = 0;
  int nErrors = 0;

  memory_write_data_encoder #(
    .AW         (AW),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ds     (req_ds),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one accept edge
  task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] ds);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_ds    = ds;
    tick();
    req_valid = 1'b0;
    req_data  = 32'hA5A5A5A5;
  endtask

  task automatic wordStore(input string tag, input logic [31:0] addr, input logic [31:0] data);
    issue(addr, data, 2'd0);
    checkVal({tag, "_wr"},    {31'd0, mem_wr}, 32'd1);
    checkVal({tag, "_done"},  {31'd0, done},   32'd1);
    checkVal({tag, "_rd"},    {31'd0, mem_rd}, 32'd0);
    checkVal({tag, "_addr"},  {2'b00, mem_addr}, addr >> 2);
    checkVal({tag, "_wdata"}, mem_wdata, data);
    checkVal({tag, "_rdy"},   {31'd0, req_ready}, 32'd0);
    tick();
    checkVal({tag, "_wr_end"}, {31'd0, mem_wr}, 32'd0);
    checkVal({tag, "_rdy_end"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Sub-word store: rvalid arrives 'delay' cycles after the read strobe.
  // A junk rvalid is driven during the strobe cycle and must be ignored.
  task automatic subStore(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] ds, input logic [31:0] memWord, input int delay,
                          input logic [31:0] expWord);
    issue(addr, data, ds);
    checkVal({tag, "_rd"},   {31'd0, mem_rd}, 32'd1);
    checkVal({tag, "_addr"}, {2'b00, mem_addr}, addr >> 2);
    checkVal({tag, "_wr0"},  {31'd0, mem_wr}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    for (int i = 1; i <= delay; i++) begin
      tick();
      if (i == delay) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memWord;
      end else begin
        mem_rvalid = 1'b0;
      end
      checkVal({tag, "_nowr"}, {31'd0, mem_wr | mem_rd}, 32'd0);
    end
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkVal({tag, "_wr"},    {31'd0, mem_wr}, 32'd1);
    checkVal({tag, "_done"},  {31'd0, done},   32'd1);
    checkVal({tag, "_wdata"}, mem_wdata, expWord);
    tick();
    checkVal({tag, "_wr_end"},  {31'd0, mem_wr}, 32'd0);
    checkVal({tag, "_rdy_end"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic sawBad;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_ds     = 2'd0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkVal("rst_rdy",   {31'd0, req_ready}, 32'd1);
    checkVal("rst_strb",  {28'd0, mem_rd, mem_wr, done, err}, 32'd0);
    checkVal("rst_addr",  {2'b00, mem_addr}, 32'd0);
    checkVal("rst_wdata", mem_wdata, 32'd0);

    // Word store
    wordStore("word", 32'h100, 32'hDEADBEEF);

    // Sub-word read-modify-write stores
    subStore("byte1", 32'h101, 32'h000000AB, 2'd2, 32'h11223344, 2, 32'h11AB3344);
    subStore("half3", 32'h103, 32'h0000CAFE, 2'd1, 32'h11223344, 1, 32'h1122CAFE);
    subStore("half0", 32'h200, 32'hFFFFCAFE, 2'd1, 32'h11223344, 1, 32'hCAFE3344);
    subStore("byte3", 32'h007, 32'h12345655, 2'd2, 32'h11223344, 3, 32'h11223355);
    subStore("byte0", 32'h004, 32'h000000EE, 2'd2, 32'h11223344, 1, 32'hEE223344);

    // Illegal size
    issue(32'h10, 32'h12345678, 2'd3);
    checkVal("ill_err",  {31'd0, err}, 32'd1);
    checkVal("ill_rdwr", {30'd0, mem_rd, mem_wr}, 32'd0);
    checkVal("ill_rdy",  {31'd0, req_ready}, 32'd0);
    tick();
    checkVal("ill_err_end", {31'd0, err}, 32'd0);
    checkVal("ill_rdy_end", {31'd0, req_ready}, 32'd1);

    // Read timeout: err exactly RD_TIMEOUT+1 cycles after the read strobe
    issue(32'h101, 32'h000000AB, 2'd2);
    checkVal("to_rd", {31'd0, mem_rd}, 32'd1);
    sawBad = 1'b0;
    for (int k = 1; k <= RD_TIMEOUT; k++) begin
      tick();
      if (err || mem_wr || mem_rd) sawBad = 1'b1;
    end
    checkVal("to_early", {31'd0, sawBad}, 32'd0);
    tick();
    checkVal("to_err",  {31'd0, err}, 32'd1);
    checkVal("to_nowr", {31'd0, mem_wr}, 32'd0);
    tick();
    checkVal("to_rdy", {31'd0, req_ready}, 32'd1);

    // Stray rvalid while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCCCCCCCC;
    tick();
    tick();
    mem_rvalid = 1'b0;
    checkVal("stray_strb", {28'd0, mem_rd, mem_wr, done, err}, 32'd0);
    checkVal("stray_rdy",  {31'd0, req_ready}, 32'd1);

    // Reset while waiting for read data
    issue(32'h101, 32'h000000AB, 2'd2);
    tick();
    rst_n      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b0;
    checkVal("mrst_strb",  {28'd0, mem_rd, mem_wr, done, err}, 32'd0);
    checkVal("mrst_addr",  {2'b00, mem_addr}, 32'd0);
    checkVal("mrst_wdata", mem_wdata, 32'd0);
    checkVal("mrst_rdy",   {31'd0, req_ready}, 32'd1);
    tick();
    checkVal("mrst_idle", {31'd0, mem_wr}, 32'd0);
    wordStore("post", 32'h3FC, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
